// File: rtl/tile_command_queue.sv
// tile_command_queue
// Buffers CPU tile commands in a FIFO and replays them to the colour mapper
// only during vertical blank. Issued words are held on control for one cycle
// and followed by GAP zero cycles. Malformed writes and writes into a full
// FIFO are dropped and recorded in sticky flags.
//
// Handshake: there is no backpressure. wr_en is a one-cycle strobe that is
// either accepted or dropped in the same cycle. control is a registered
// one-cycle pulse that carries no valid signal; a nonzero word means "issue".
module tile_command_queue #(
  parameter int DEPTH       = 16,  // power of two, >= 2
  parameter int GAP         = 2,   // zero cycles between issues, >= 1
  parameter int ACTIVE_ROWS = 480  // first scanline of vertical blank
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic [9:0]               y,
  input  logic                     clear_flags,
  output logic [31:0]              control,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     range_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     state_dbg
);

  localparam int AW  = $clog2(DEPTH);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic {ST_ISSUE = 1'b0, ST_SPACE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_q;
  logic [31:0]      control_q;
  logic             ovf_q, rng_q;

  logic             window, pop, push;
  logic             cmd_op2, in_range, ovf_set, rng_set;

  // Command decode: opcode 2 only, column < 40, row < 30.
  assign cmd_op2  = wr_en && (wr_data[31:28] == 4'h2);
  assign in_range = (wr_data[27:22] < 6'd40) && (wr_data[21:16] < 6'd30);
  assign window   = (y >= 10'(ACTIVE_ROWS));

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);

  // A pop in the same cycle frees the slot for a write arriving while full.
  assign push    = cmd_op2 && in_range && (!full || pop);
  assign ovf_set = cmd_op2 && in_range && full && !pop;
  assign rng_set = cmd_op2 && !in_range;

  // Issue/spacing FSM: next state, gap counter and pop decision.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (window && !empty) begin
          pop     = 1'b1;
          state_d = ST_SPACE;
          gap_d   = '0;
        end
      end
      ST_SPACE: begin
        // Spacing ignores the window so an issue begun in blank completes.
        if (gap_q == GCW'(GAP - 1)) begin
          state_d = ST_ISSUE;
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // FSM state, pointers, occupancy, output word and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ISSUE;
      gap_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      control_q <= '0;
      ovf_q     <= 1'b0;
      rng_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      control_q <= pop ? mem[rd_ptr] : 32'h0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      // A new error in the clearing cycle wins over the clear.
      if (ovf_set)          ovf_q <= 1'b1;
      else if (clear_flags) ovf_q <= 1'b0;
      if (rng_set)          rng_q <= 1'b1;
      else if (clear_flags) rng_q <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written, pointers gate use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign control   = control_q;
  assign overflow  = ovf_q;
  assign range_err = rng_q;
  assign level     = level_q;
  assign state_dbg = state_q;

endmodule
